arc_memory: RTL and testbench
=============================

# arc_memory

Parametrised, word-organised, byte-addressed main memory for the ARC softcore with a request/acknowledge handshake, programmable wait states, address/alignment error reporting and optional zero-fill after reset. It replaces fixed-size, always-ready storage as the CPU's single instruction/data memory port. Every access is a registered transaction, so the control unit waits on `ack` rather than assuming fixed latency.

## Interface
- `DATA_W`, default 32: data word width in bits.
- `ADDR_W`, default 32: byte address width.
- `DEPTH`, default 4096: number of words; a power of two, at least 4.
- `WAIT_STATES`, default 0: extra cycles between request acceptance and `ack`; valid range 0–15.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset; one clock, reset sampled on the rising edge of `clk`.
- `address`  in  ADDR_W  byte address of the access.
- `data_in`  in  DATA_W  write data.
- `rd`  in  1  read request.
- `wr`  in  1  write request.
- `ready`  out  1  module can accept a request this cycle.
- `ack`  out  1  one-cycle pulse that completes a transaction.
- `err`  out  1  valid with `ack`: the transaction was rejected.
- `data_out`  out  DATA_W  read data; valid with `ack`.

## Operation
- Word index is `address[log2(DEPTH)+1:2]`.
- An access is in range when `address < DEPTH*4`, `address[1:0]==0`, and exactly one of `rd`/`wr` is high.
- FSM states are CLEAR, IDLE, WAIT and RESP.
- CLEAR is present only with the macro (see Configuration). It writes zero to word 0..DEPTH-1, one word per cycle, then goes to IDLE.
- IDLE: `ready`=1.
  - With `rd|wr` high, the module captures `address`, `data_in`, `rd` and `wr`.
  - It then goes to WAIT if `WAIT_STATES`>0, otherwise to RESP.
- WAIT: a 4-bit counter loads `WAIT_STATES-1` on entry and decrements each cycle. The FSM goes to RESP when the counter reaches 0.
- RESP: `ack`=1 for exactly one cycle, then the FSM returns to IDLE.
  - Valid write: the array is updated at the RESP edge. `data_out` holds its previous value and `err`=0.
  - Valid read: `data_out` = array word at the captured index and `err`=0.
  - Invalid access (out of range, misaligned, or `rd`&`wr` both high): no array write, `data_out`=0, `err`=1.
- Inputs are sampled only at acceptance. Changes while busy are ignored.
- Requests presented while `ready`=0 are not queued. The master holds them until `ready`=1.

## Timing
- Reset state while `rst`=1: `ready`=0, `ack`=0, `err`=0, `data_out`=0. The FSM enters CLEAR (macro defined) or IDLE (macro undefined).
- Reset in any state aborts the pending transaction. No `ack` is issued and no write occurs for it.
- Latency: acceptance edge to the `ack` cycle is `WAIT_STATES`+1 cycles.
- Throughput: one transaction per `WAIT_STATES`+2 cycles. `ready`=0 in WAIT and RESP.
- `err`, `ack` and `data_out` are registered outputs. `err` and `data_out` hold their values after `ack` falls.
- Read-after-write to the same word: the next transaction returns the new data.
- Address `DEPTH*4-4` is the last valid word; `DEPTH*4` gives `err`.
- Index arithmetic never wraps: upper address bits are compared, not truncated.

## Configuration
- `ARC_MEM_CLEAR_EN` defined:
  - Every reset is followed by DEPTH CLEAR cycles with `ready`=0.
  - Afterwards every word reads 0.
  - `ready` rises DEPTH cycles after `rst` falls.
- `ARC_MEM_CLEAR_EN` undefined:
  - The CLEAR state and the clear counter are not built.
  - `ready`=1 on the first cycle after `rst` falls.
  - Array contents survive reset; initial content comes from simulation or synthesis init.

## Test plan
- Reset → clear check (macro on, DEPTH=1024): pulse `rst` → `ready` stays 0 for 1024 cycles then rises. Read 0x0, 0x800 and 0xFFC → `data_out`=0, `err`=0.
- Write/read (WAIT_STATES=2):
  - Write 0xC2002814 to 0x800 → `ack` 3 cycles after acceptance, `err`=0.
  - Then read 0x800 → `data_out`=0xC2002814.
- Back-to-back: write 0xF to 0x810, then immediately read 0x810 when `ready` returns → 0xF. `ready` is low for exactly 3 cycles per transaction.
- Errors:
  - Read 0x1000 (DEPTH=1024) → `err`=1, `data_out`=0.
  - Write to 0x802 → `err`=1 and the word at 0x800 is unchanged.
  - `rd`=`wr`=1 → `err`=1, no write.
- Reset mid-transaction: accept a write of 0x3 to 0x814, assert `rst` during WAIT → no `ack`. With the macro off, reading 0x814 after reset returns its pre-write value.
- Input stability: change `address`/`data_in` during WAIT → the response reflects the values captured at acceptance.

Source files
------------

// File: rtl/arc_memory.sv
// arc_memory: byte-addressed word memory with rd/wr request and ack pulse.
// Define ARC_MEM_CLEAR_EN to zero-fill the whole array after every reset.
module arc_memory #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              wr,
  output logic              ready,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] data_out
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(longint'(DEPTH) * 4);
  localparam logic [3:0] WS_M1 =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

`ifdef ARC_MEM_CLEAR_EN
  typedef enum logic [1:0] {
    S_CLEAR, S_IDLE, S_WAIT, S_RESP
  } state_t;
  localparam state_t S_RST = S_CLEAR;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_RESP
  } state_t;
  localparam state_t S_RST = S_IDLE;
`endif

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              rd_q, wr_q;

  logic              ack_q, err_q;
  logic [DATA_W-1:0] dout_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, go_resp;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_din;
  logic              op_rd, op_wr, op_ok;
  logic [IDX_W-1:0]  op_idx;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wd;

`ifdef ARC_MEM_CLEAR_EN
  logic [IDX_W-1:0]  clr_q;

  // Clear pointer walks the array once after each reset
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q <= '0;
    end else if (state_q == S_CLEAR) begin
      clr_q <= clr_q + IDX_W'(1);
    end
  end
`endif

  assign accept = (state_q == S_IDLE) && (rd || wr);

  // With zero wait states the response is built from the live inputs
  always_comb begin
    op_addr = addr_q;
    op_din  = din_q;
    op_rd   = rd_q;
    op_wr   = wr_q;
    if (state_q == S_IDLE) begin
      op_addr = address;
      op_din  = data_in;
      op_rd   = rd;
      op_wr   = wr;
    end
  end

  assign op_ok = ({1'b0, op_addr} < LIMIT)
              && (op_addr[1:0] == 2'b00)
              && (op_rd ^ op_wr);
  assign op_idx = op_addr[IDX_W+1:2];

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
`ifdef ARC_MEM_CLEAR_EN
      S_CLEAR: begin
        if (clr_q == IDX_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
        end
      end
`endif
      S_IDLE: begin
        if (rd || wr) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_M1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_RST;
    endcase
  end

  assign go_resp = (state_d == S_RESP) && (state_q != S_RESP);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture at acceptance; later input changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else if (accept) begin
      addr_q <= address;
      din_q  <= data_in;
      rd_q   <= rd;
      wr_q   <= wr;
    end
  end

  // Array write port shared by clear sweep and write responses
  always_comb begin
    mem_we  = go_resp && op_ok && op_wr && !rst;
    mem_idx = op_idx;
    mem_wd  = op_din;
`ifdef ARC_MEM_CLEAR_EN
    if (state_q == S_CLEAR) begin
      mem_we  = !rst;
      mem_idx = clr_q;
      mem_wd  = '0;
    end
`endif
  end

  // Storage array, no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wd;
    end
  end

  // Registered response; err and data_out hold between acks
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      ack_q <= go_resp;
      if (go_resp) begin
        err_q <= !op_ok;
        if (!op_ok) begin
          dout_q <= '0;
        end else if (op_rd) begin
          dout_q <= mem[op_idx];
        end
      end
    end
  end

  assign ready    = (state_q == S_IDLE) && !rst;
  assign ack      = ack_q;
  assign err      = err_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_arc_memory.sv
// tb_arc_memory: directed bench for arc_memory with a
// transaction-level model checked against the DUT every cycle.
module tb_arc_memory;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int WS    = 2;
`ifdef ARC_MEM_CLEAR_EN
  localparam int CLR = DEPTH;
`else
  localparam int CLR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_in = '0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic          ready, ack, err;
  logic [DW-1:0] data_out;

  arc_memory #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .data_in(data_in),
    .rd(rd),
    .wr(wr),
    .ready(ready),
    .ack(ack),
    .err(err),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk1(input string nm,
                               input logic got,
                               input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b cycle %0d",
               nm, got, exp, cyc);
    end
  endfunction

  function automatic void chk32(input string nm,
                                input logic [31:0] got,
                                input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h cycle %0d",
               nm, got, exp, cyc);
    end
  endfunction

  function automatic void chki(input string nm,
                               input int got,
                               input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d cycle %0d",
               nm, got, exp, cyc);
    end
  endfunction

  // Model: word contents by index, plus current output state
  logic [31:0] mm [int];
  logic [31:0] m_dout = '0;
  bit          m_dout_k = 1'b1;
  logic        m_err = 1'b0;

  // Pending transaction
  bit          ev = 1'b0;
  int          e_acc = 0;
  logic        e_err;
  logic        e_wr;
  int          e_idx;
  logic [31:0] e_wd;
  logic [31:0] e_dout;
  bit          e_dout_k;

  int rst_start = 0;
  int rst_rel = -100;

  bit busy, exp_ack, exp_rdy;

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cyc == rst_start || cyc == rst_rel) begin
    end else if (rst) begin
      if (cyc > rst_start) begin
        chk1("rst_ready", ready, 1'b0);
        chk1("rst_ack", ack, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_dout", data_out, 32'h0);
      end
    end else begin
      busy    = ev && cyc >= e_acc;
      exp_ack = ev && cyc == e_acc + WS;
      exp_rdy = !busy && cyc >= rst_rel + CLR;
      chk1("ready", ready, exp_rdy);
      chk1("ack", ack, exp_ack);
      if (exp_ack) begin
        chk1("ack_err", err, e_err);
        if (e_dout_k) chk32("ack_dout", data_out, e_dout);
        if (!e_err && e_wr) mm[e_idx] = e_wd;
        m_err    = e_err;
        m_dout   = e_dout;
        m_dout_k = e_dout_k;
        ev = 1'b0;
      end else begin
        chk1("hold_err", err, m_err);
        if (m_dout_k) chk32("hold_dout", data_out, m_dout);
      end
    end
  end

  // Called at a falling edge; holds rst for ncyc cycles
  task automatic do_reset(input int ncyc);
    rst_start = cyc;
    rst = 1'b1;
    ev = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    repeat (ncyc) @(negedge clk);
    rst_rel = cyc;
    m_err = 1'b0;
    m_dout = '0;
    m_dout_k = 1'b1;
`ifdef ARC_MEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
`endif
    rst = 1'b0;
  endtask

  // Wait for ready, present a request and build the model expectation
  task automatic issue(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic r,
                       input logic w,
                       output bit ok);
    int n;
    bit v;
    n = 0;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = ready;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got 0 expected 1 cycle %0d", cyc);
      return;
    end
    address = a;
    data_in = d;
    rd = r;
    wr = w;
    v = (a < DEPTH * 4) && (a[1:0] == 2'b00) && (r != w);
    e_err = !v;
    e_wr = w;
    e_idx = int'(a >> 2);
    e_wd = d;
    if (!v) begin
      e_dout = '0;
      e_dout_k = 1'b1;
    end else if (w) begin
      e_dout = m_dout;
      e_dout_k = m_dout_k;
    end else if (mm.exists(e_idx)) begin
      e_dout = mm[e_idx];
      e_dout_k = 1'b1;
    end else begin
      e_dout = '0;
      e_dout_k = 1'b0;
    end
    e_acc = cyc + 1;
    ev = 1'b1;
    @(posedge clk);
    #1;
    address = a ^ 32'h10;
    data_in = ~d;
    rd = w;
    wr = r;
  endtask

  logic [31:0] od;
  logic        oe;
  int          lowc;

  task automatic xact(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic r,
                      input logic w);
    bit ok;
    od = '0;
    oe = 1'b0;
    lowc = 0;
    issue(a, d, r, w, ok);
    if (!ok) return;
    do begin
      @(negedge clk);
      if (!ready) lowc++;
      if (cyc == e_acc + WS) begin
        od = data_out;
        oe = err;
      end
    end while (cyc < e_acc + WS + 1);
    rd = 1'b0;
    wr = 1'b0;
  endtask

  initial begin
    bit ok;
    do_reset(3);

`ifdef ARC_MEM_CLEAR_EN
    xact(32'h0, 32'h0, 1'b1, 1'b0);
    chk32("clr_0", od, 32'h0);
    chk1("clr_0_err", oe, 1'b0);
    xact(32'h800, 32'h0, 1'b1, 1'b0);
    chk32("clr_800", od, 32'h0);
    xact(32'hFFC, 32'h0, 1'b1, 1'b0);
    chk32("clr_ffc", od, 32'h0);
`endif

    xact(32'h800, 32'hC2002814, 1'b0, 1'b1);
    chk1("wr800_err", oe, 1'b0);
    chki("wr800_busy", lowc, 3);
    xact(32'h800, 32'h0, 1'b1, 1'b0);
    chk32("rd800", od, 32'hC2002814);

    xact(32'h810, 32'hF, 1'b0, 1'b1);
    chki("b2b_wr_busy", lowc, 3);
    xact(32'h810, 32'h0, 1'b1, 1'b0);
    chk32("b2b_rd810", od, 32'hF);
    chki("b2b_rd_busy", lowc, 3);

    xact(32'h1000, 32'h0, 1'b1, 1'b0);
    chk1("oob_err", oe, 1'b1);
    chk32("oob_dout", od, 32'h0);

    xact(32'h802, 32'h12345678, 1'b0, 1'b1);
    chk1("mis_err", oe, 1'b1);
    xact(32'h800, 32'h0, 1'b1, 1'b0);
    chk32("mis_nowrite", od, 32'hC2002814);

    xact(32'h800, 32'h55, 1'b1, 1'b1);
    chk1("both_err", oe, 1'b1);
    xact(32'h800, 32'h0, 1'b1, 1'b0);
    chk32("both_nowrite", od, 32'hC2002814);

    xact(32'hFFC, 32'h11112222, 1'b0, 1'b1);
    chk1("last_wr_err", oe, 1'b0);
    xact(32'hFFC, 32'h0, 1'b1, 1'b0);
    chk32("last_rd", od, 32'h11112222);
    xact(32'h0001_0800, 32'h0, 1'b1, 1'b0);
    chk1("nowrap_err", oe, 1'b1);

    xact(32'h808, 32'h808, 1'b0, 1'b1);
    xact(32'h818, 32'h77, 1'b0, 1'b1);
    xact(32'h818, 32'h0, 1'b1, 1'b0);
    chk32("stable_818", od, 32'h77);
    xact(32'h808, 32'h0, 1'b1, 1'b0);
    chk32("stable_808", od, 32'h808);

    xact(32'h814, 32'hA5A50814, 1'b0, 1'b1);
    issue(32'h814, 32'h3, 1'b0, 1'b1, ok);
    @(negedge clk);
    do_reset(2);
    rd = 1'b0;
    wr = 1'b0;
    @(negedge clk);
    xact(32'h814, 32'h0, 1'b1, 1'b0);
`ifdef ARC_MEM_CLEAR_EN
    chk32("abort_rd814", od, 32'h0);
`else
    chk32("abort_rd814", od, 32'hA5A50814);
`endif
    chk1("abort_err", oe, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
